// File: rtl/pattern_scan_ctrl_if.sv
// Command, detector and result signals of the pattern scan controller.
// The slave modport is the controller's view, master is the requester/detector side.
interface pattern_scan_ctrl_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 5,
   parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [4:0]        cmd_pattern;
   logic [DATA_W-1:0] cmd_data;
   logic [LEN_W-1:0]  cmd_len;
   logic              abort;

   logic              det_load;
   logic [4:0]        det_pattern;
   logic              det_serial;
   logic              det_patt;

   logic              res_valid;
   logic [CNT_W-1:0]  res_count;
   logic [CNT_W-1:0]  res_first_idx;
   logic              res_found;

   modport slave (
      input  cmd_valid, cmd_pattern, cmd_data, cmd_len, abort, det_patt,
      output cmd_ready, det_load, det_pattern, det_serial,
             res_valid, res_count, res_first_idx, res_found
   );

   modport master (
      output cmd_valid, cmd_pattern, cmd_data, cmd_len, abort, det_patt,
      input  cmd_ready, det_load, det_pattern, det_serial,
             res_valid, res_count, res_first_idx, res_found
   );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Sequencer for a 5-bit serial pattern detector: loads the pattern, shifts a data
// word in MSB-first and reports match count / first-match index when done.
module pattern_scan_ctrl #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned LEN_W   = 5,
   parameter int unsigned DET_LAT = 1,
   parameter int unsigned CNT_W   = $clog2(DATA_W + 1)
) (
   input logic                clk,
   input logic                reset_n,
   pattern_scan_ctrl_if.slave bus
);

   localparam int unsigned CYC_W = CNT_W + 2;
   localparam logic [CYC_W-1:0] LAT     = CYC_W'(DET_LAT);
   localparam logic [CYC_W-1:0] MIN_IDX = CYC_W'(4);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0]  acc_first_q, acc_first_d;

   logic              ready_q, ready_d;
   logic              load_q, load_d;
   logic              serial_q, serial_d;
   logic [4:0]        pattern_q, pattern_d;
   logic              res_valid_q, res_valid_d;
   logic [CNT_W-1:0]  res_count_q, res_count_d;
   logic [CNT_W-1:0]  res_first_q, res_first_d;
   logic              res_found_q, res_found_d;

   logic [CYC_W-1:0]  len_x;
   logic [CYC_W-1:0]  samp_idx;
   logic              samp_hit;
   logic [CNT_W-1:0]  eff_len;
   logic              finish;

   // det_patt seen now answers the bit driven DET_LAT cycles ago (index cyc - DET_LAT)
   always_comb begin
      len_x    = CYC_W'(len_q);
      samp_idx = cyc_q - LAT;
      samp_hit = ((state_q == S_SHIFT) || (state_q == S_DRAIN)) &&
                 (cyc_q >= LAT) && (samp_idx >= MIN_IDX) && (samp_idx < len_x) &&
                 bus.det_patt;
      eff_len  = (bus.cmd_len > MAX_LEN) ? CNT_W'(DATA_W) : CNT_W'(bus.cmd_len);
   end

   // next-state and output decode
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      len_d       = len_q;
      cyc_d       = cyc_q;
      acc_cnt_d   = acc_cnt_q;
      acc_first_d = acc_first_q;
      load_d      = 1'b0;
      serial_d    = 1'b0;
      pattern_d   = pattern_q;
      res_valid_d = 1'b0;
      res_count_d = res_count_q;
      res_first_d = res_first_q;
      res_found_d = res_found_q;
      finish      = 1'b0;

      if (samp_hit) begin
         acc_cnt_d = acc_cnt_q + CNT_W'(1);
         if (acc_cnt_q == '0) begin
            acc_first_d = CNT_W'(samp_idx);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               pattern_d   = bus.cmd_pattern;
               data_d      = bus.cmd_data;
               len_d       = eff_len;
               cyc_d       = '0;
               acc_cnt_d   = '0;
               acc_first_d = '0;
               if (eff_len == '0) begin
                  state_d = S_DONE;
                  finish  = 1'b1;
               end else begin
                  state_d = S_LOAD;
                  load_d  = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_SHIFT;
               serial_d = data_q[DATA_W-1];
               data_d   = data_q << 1;
               cyc_d    = '0;
            end
         end
         S_SHIFT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (cyc_q == len_x - CYC_W'(1)) begin
               cyc_d = cyc_q + CYC_W'(1);
               if (DET_LAT == 0) begin
                  state_d = S_DONE;
                  finish  = 1'b1;
               end else begin
                  state_d = S_DRAIN;
               end
            end else begin
               cyc_d    = cyc_q + CYC_W'(1);
               serial_d = data_q[DATA_W-1];
               data_d   = data_q << 1;
            end
         end
         S_DRAIN: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
               if (cyc_q == len_x - CYC_W'(1) + LAT) begin
                  state_d = S_DONE;
                  finish  = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // results include a match sampled in the very cycle that enters DONE
      if (finish) begin
         res_valid_d = 1'b1;
         res_count_d = acc_cnt_d;
         res_first_d = acc_first_d;
         res_found_d = (acc_cnt_d != '0);
      end

      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         data_q      <= '0;
         len_q       <= '0;
         cyc_q       <= '0;
         acc_cnt_q   <= '0;
         acc_first_q <= '0;
         ready_q     <= 1'b1;
         load_q      <= 1'b0;
         serial_q    <= 1'b0;
         pattern_q   <= '0;
         res_valid_q <= 1'b0;
         res_count_q <= '0;
         res_first_q <= '0;
         res_found_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         len_q       <= len_d;
         cyc_q       <= cyc_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_first_q <= acc_first_d;
         ready_q     <= ready_d;
         load_q      <= load_d;
         serial_q    <= serial_d;
         pattern_q   <= pattern_d;
         res_valid_q <= res_valid_d;
         res_count_q <= res_count_d;
         res_first_q <= res_first_d;
         res_found_q <= res_found_d;
      end
   end

   assign bus.cmd_ready     = ready_q;
   assign bus.det_load      = load_q;
   assign bus.det_pattern   = pattern_q;
   assign bus.det_serial    = serial_q;
   assign bus.res_valid     = res_valid_q;
   assign bus.res_count     = res_count_q;
   assign bus.res_first_idx = res_first_q;
   assign bus.res_found     = res_found_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a DET_LAT=1 detector model; per-cycle
// strobe traces are collected into bit vectors and compared with hand-derived values.
module tb_pattern_scan_ctrl;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LEN_W  = 5;
   localparam int unsigned CNT_W  = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pattern_scan_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

   pattern_scan_ctrl #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W),
      .DET_LAT(1),
      .CNT_W  (CNT_W)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus.slave)
   );

   // detector model: pattern latched on load, one-cycle registered match response
   logic [4:0] det_sh = '0;
   logic [4:0] det_pat = '0;
   logic       force_patt = 1'b0;

   always @(posedge clk) begin
      if (bus.det_load) det_pat <= bus.det_pattern;
      det_sh <= {det_sh[3:0], bus.det_serial};
   end

   assign bus.det_patt = force_patt | (det_sh == det_pat);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input int cnt, input int first, input int found);
      chk({tag, ".count"}, 32'(bus.res_count), 32'(cnt));
      chk({tag, ".first_idx"}, 32'(bus.res_first_idx), 32'(first));
      chk({tag, ".found"}, 32'(bus.res_found), 32'(found));
   endtask

   // Issue one command in cycle 0 (caller sits just after an edge) and trace ncyc cycles.
   task automatic scan(input logic [4:0] p, input logic [15:0] d, input logic [4:0] l,
                       input int ncyc, input int abort_cyc,
                       output logic [31:0] lv, output logic [31:0] sv,
                       output logic [31:0] vv, output logic [31:0] rv);
      lv = '0; sv = '0; vv = '0; rv = '0;
      bus.cmd_pattern = p;
      bus.cmd_data    = d;
      bus.cmd_len     = l;
      bus.cmd_valid   = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         if (c == 1) bus.cmd_valid = 1'b0;
         bus.abort = (c == abort_cyc);
         @(negedge clk);
         lv[c] = bus.det_load;
         sv[c] = bus.det_serial;
         vv[c] = bus.res_valid;
         rv[c] = bus.cmd_ready;
         @(posedge clk); #1;
      end
      bus.abort = 1'b0;
   endtask

   task automatic chk_trace(input string tag, input logic [31:0] lv, input logic [31:0] sv,
                            input logic [31:0] vv, input logic [31:0] rv,
                            input logic [31:0] el, input logic [31:0] es,
                            input logic [31:0] ev, input logic [31:0] er);
      chk({tag, ".det_load"}, lv, el);
      chk({tag, ".det_serial"}, sv, es);
      chk({tag, ".res_valid"}, vv, ev);
      chk({tag, ".cmd_ready"}, rv, er);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".det_load"}, 32'(bus.det_load), 32'd0);
      chk({tag, ".det_serial"}, 32'(bus.det_serial), 32'd0);
      chk({tag, ".res_valid"}, 32'(bus.res_valid), 32'd0);
      chk({tag, ".det_pattern"}, 32'(bus.det_pattern), 32'd0);
      chk_res(tag, 0, 0, 0);
   endtask

   logic [31:0] lv, sv, vv, rv;

   initial begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_pattern = '0;
      bus.cmd_data    = '0;
      bus.cmd_len     = '0;
      bus.abort       = 1'b0;

      #1 reset_n = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset.cmd_ready", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk); #1;

      // 1,1,0,1,1,0,1,1 -> matches at k=4 and k=7
      scan(5'b11011, 16'hDB00, 5'd8, 14, -1, lv, sv, vv, rv);
      chk_trace("basic", lv, sv, vv, rv, 32'h2, 32'h36C, 32'h800, 32'h3001);
      chk_res("basic", 2, 4, 1);

      // len 20 clamps to 16; matches at k=4..15
      scan(5'b11111, 16'hFFFF, 5'd20, 22, -1, lv, sv, vv, rv);
      chk_trace("sat", lv, sv, vv, rv, 32'h2, 32'h3FFFC, 32'h80000, 32'h300001);
      chk_res("sat", 12, 4, 1);

      scan(5'b11011, 16'hDB00, 5'd0, 4, -1, lv, sv, vv, rv);
      chk_trace("zero", lv, sv, vv, rv, 32'h0, 32'h0, 32'h2, 32'hD);
      chk_res("zero", 0, 0, 0);

      // det_patt stuck high, but every index is below the counting window
      force_patt = 1'b1;
      scan(5'b11111, 16'hF000, 5'd4, 9, -1, lv, sv, vv, rv);
      force_patt = 1'b0;
      chk_trace("gate", lv, sv, vv, rv, 32'h2, 32'h3C, 32'h80, 32'h101);
      chk_res("gate", 0, 0, 0);

      scan(5'b11011, 16'hDB00, 5'd8, 14, -1, lv, sv, vv, rv);
      chk_trace("basic2", lv, sv, vv, rv, 32'h2, 32'h36C, 32'h800, 32'h3001);
      chk_res("basic2", 2, 4, 1);

      // abort in the third SHIFT cycle (cycle 4)
      scan(5'b11011, 16'hDB00, 5'd8, 8, 4, lv, sv, vv, rv);
      chk_trace("abort", lv, sv, vv, rv, 32'h2, 32'hC, 32'h0, 32'hE1);
      chk_res("abort", 2, 4, 1);

      // back-to-back with cmd_valid held; second command switched in during DONE
      lv = '0; sv = '0; vv = '0; rv = '0;
      bus.cmd_pattern = 5'b11011;
      bus.cmd_data    = 16'hDB00;
      bus.cmd_len     = 5'd8;
      bus.cmd_valid   = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (c == 11) begin
            bus.cmd_pattern = 5'b11111;
            bus.cmd_data    = 16'hFFFF;
            bus.cmd_len     = 5'd6;
         end
         @(negedge clk);
         lv[c] = bus.det_load;
         sv[c] = bus.det_serial;
         vv[c] = bus.res_valid;
         rv[c] = bus.cmd_ready;
         @(posedge clk); #1;
      end
      chk_trace("b2b", lv, sv, vv, rv, 32'h2002, 32'hC36C, 32'h800, 32'h1001);
      chk("b2b.count_held", 32'(bus.res_count), 32'd2);

      // reset in the middle of the second command's SHIFT phase
      bus.cmd_valid = 1'b0;
      reset_n = 1'b0;
      #2;
      chk_all_zero("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midreset.cmd_ready", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk); #1;

      scan(5'b11111, 16'hFFFF, 5'd6, 11, -1, lv, sv, vv, rv);
      chk_trace("post", lv, sv, vv, rv, 32'h2, 32'hFC, 32'h200, 32'h401);
      chk_res("post", 2, 4, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
